// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller cpu port between three toggle-handshake clients
module sdram_port_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_req,
    output logic        c0_ack,
    input  logic        c0_we,
    input  logic [24:0] c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic [3:0]  c0_be,
    output logic [31:0] c0_rdata,
    input  logic        c1_req,
    output logic        c1_ack,
    input  logic        c1_we,
    input  logic [24:0] c1_addr,
    input  logic [31:0] c1_wdata,
    input  logic [3:0]  c1_be,
    output logic [31:0] c1_rdata,
    input  logic        c2_req,
    output logic        c2_ack,
    input  logic        c2_we,
    input  logic [24:0] c2_addr,
    input  logic [31:0] c2_wdata,
    input  logic [3:0]  c2_be,
    output logic [31:0] c2_rdata,
    output logic        sd_rd,
    output logic [24:0] sd_raddr,
    input  logic        sd_rd_rdy,
    input  logic [31:0] sd_dout,
    output logic        sd_we,
    output logic [24:0] sd_waddr,
    output logic [31:0] sd_din,
    output logic [3:0]  sd_be,
    input  logic        sd_we_rdy
);
    typedef enum logic [1:0] {IDLE, ACCEPT, DONE} state_t;
    state_t      state, state_n;
    logic [2:0]  req, ack, pend;
    logic [31:0] rdata [3];
    logic [1:0]  nxt, base, alt1, alt2, sel, gnt;
    logic        wr, rdy, any, s_we;
    logic [24:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;

    assign req      = {c2_req, c1_req, c0_req};
    assign c0_ack   = ack[0];
    assign c1_ack   = ack[1];
    assign c2_ack   = ack[2];
    assign c0_rdata = rdata[0];
    assign c1_rdata = rdata[1];
    assign c2_rdata = rdata[2];

    // arbitration pick, selected client's request fields and next state
    always_comb begin
        pend    = req ^ ack;
        any     = |pend;
        base    = PRIO_FIXED ? 2'd0 : nxt;
        alt1    = base == 2'd2 ? 2'd0 : base + 2'd1;
        alt2    = base == 2'd0 ? 2'd2 : base - 2'd1;
        sel     = pend[base] ? base : pend[alt1] ? alt1 : alt2;
        s_we    = sel == 2'd0 ? c0_we    : sel == 2'd1 ? c1_we    : c2_we;
        s_addr  = sel == 2'd0 ? c0_addr  : sel == 2'd1 ? c1_addr  : c2_addr;
        s_wdata = sel == 2'd0 ? c0_wdata : sel == 2'd1 ? c1_wdata : c2_wdata;
        s_be    = sel == 2'd0 ? c0_be    : sel == 2'd1 ? c1_be    : c2_be;
        rdy     = wr ? sd_we_rdy : sd_rd_rdy;
        state_n = state == IDLE   ? (any ? ACCEPT : IDLE) :
                  state == ACCEPT ? (rdy ? ACCEPT : DONE) :
                                    (rdy ? IDLE : DONE);
    end

    // state, latched access towards the controller, and per-client completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sd_rd    <= 1'b0;
            sd_we    <= 1'b0;
            sd_raddr <= '0;
            sd_waddr <= '0;
            sd_din   <= '0;
            sd_be    <= '0;
            ack      <= '0;
            rdata    <= '{default: '0};
            nxt      <= 2'd0;
            gnt      <= 2'd0;
            wr       <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && any) begin
                gnt      <= sel;
                wr       <= s_we;
                sd_rd    <= !s_we;
                sd_we    <= s_we;
                sd_raddr <= s_addr;
                sd_waddr <= s_addr;
                sd_din   <= s_wdata;
                sd_be    <= s_be;
            end
            if (state == ACCEPT && !rdy) begin
                sd_rd <= 1'b0;
                sd_we <= 1'b0;
            end
            if (state == DONE && rdy) begin
                ack[gnt] <= req[gnt];
                if (!wr)
                    rdata[gnt] <= sd_dout;
                nxt <= gnt == 2'd2 ? 2'd0 : gnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: round-robin and fixed-priority arbiters against a transaction-level model
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset;
    logic        req [2][3];
    logic        we_v [2][3];
    logic [24:0] addr_v [2][3];
    logic [31:0] wd_v [2][3];
    logic [3:0]  be_v [2][3];
    logic        ack_o [2][3];
    logic [31:0] rd_o [2][3];
    logic        sd_rd [2], sd_we [2], rd_rdy [2], we_rdy [2];
    logic [24:0] raddr [2], waddr [2];
    logic [31:0] din [2], dout [2];
    logic [3:0]  sbe [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        sdram_port_arbiter #(.PRIO_FIXED(d == 1)) dut (
            .clk(clk), .reset(reset),
            .c0_req(req[d][0]), .c0_ack(ack_o[d][0]), .c0_we(we_v[d][0]), .c0_addr(addr_v[d][0]),
            .c0_wdata(wd_v[d][0]), .c0_be(be_v[d][0]), .c0_rdata(rd_o[d][0]),
            .c1_req(req[d][1]), .c1_ack(ack_o[d][1]), .c1_we(we_v[d][1]), .c1_addr(addr_v[d][1]),
            .c1_wdata(wd_v[d][1]), .c1_be(be_v[d][1]), .c1_rdata(rd_o[d][1]),
            .c2_req(req[d][2]), .c2_ack(ack_o[d][2]), .c2_we(we_v[d][2]), .c2_addr(addr_v[d][2]),
            .c2_wdata(wd_v[d][2]), .c2_be(be_v[d][2]), .c2_rdata(rd_o[d][2]),
            .sd_rd(sd_rd[d]), .sd_raddr(raddr[d]), .sd_rd_rdy(rd_rdy[d]), .sd_dout(dout[d]),
            .sd_we(sd_we[d]), .sd_waddr(waddr[d]), .sd_din(din[d]), .sd_be(sbe[d]),
            .sd_we_rdy(we_rdy[d])
        );
    end

    // model: st 0 = no access, 1 = strobe expected, 2 = accepted, awaiting completion
    int          st [2], g [2], ptr [2], dly [2];
    logic        eack [2][3];
    logic [31:0] erd [2][3];
    logic        gwe [2];
    logic [24:0] gad [2];
    logic [31:0] gwd [2];
    logic [3:0]  gbe [2];
    int          glog [2][$];
    int          p_tog [3];
    int          acc_lo, acc_hi, dn_lo, dn_hi, wmode;
    bit          do_reset, force_v;
    logic [31:0] force_dout;
    bit          want [2][3];
    logic        want_we [3];
    logic [24:0] want_ad [3];
    logic [31:0] want_wd [3];
    logic [3:0]  want_be [3];
    int          errors = 0, checks = 0;

    task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            st[d] = 0;
            ptr[d] = 0;
            rd_rdy[d] = 1'b1;
            we_rdy[d] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                eack[d][c] = 1'b0;
                erd[d][c] = '0;
                req[d][c] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        int base, s;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                chk("ack", d, ack_o[d][c], eack[d][c]);
                chk("rdata", d, rd_o[d][c], erd[d][c]);
            end
            chk("sd_rd", d, sd_rd[d], st[d] == 1 && !gwe[d]);
            chk("sd_we", d, sd_we[d], st[d] == 1 && gwe[d]);
            if (st[d] != 0) begin
                if (gwe[d]) begin
                    chk("sd_waddr", d, waddr[d], gad[d]);
                    chk("sd_din", d, din[d], gwd[d]);
                    chk("sd_be", d, sbe[d], gbe[d]);
                end else
                    chk("sd_raddr", d, raddr[d], gad[d]);
            end
        end
        reset = 1'b0;
        if (do_reset) begin
            do_reset = 1'b0;
            reset = 1'b1;
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++)
                if (req[d][c] == eack[d][c]) begin
                    if (want[d][c]) begin
                        want[d][c] = 1'b0;
                        we_v[d][c] = want_we[c];
                        addr_v[d][c] = want_ad[c];
                        wd_v[d][c] = want_wd[c];
                        be_v[d][c] = want_be[c];
                        req[d][c] = !req[d][c];
                    end else if ($urandom_range(99) < p_tog[c]) begin
                        we_v[d][c] = wmode < 0 ? 1'($urandom_range(1)) : 1'(wmode);
                        addr_v[d][c] = 25'($urandom);
                        wd_v[d][c] = $urandom;
                        be_v[d][c] = 4'($urandom);
                        req[d][c] = !req[d][c];
                    end
                end
        for (int d = 0; d < 2; d++) begin
            if (st[d] == 0) begin
                base = d == 1 ? 0 : ptr[d];
                s = -1;
                for (int k = 2; k >= 0; k--)
                    if (req[d][(base + k) % 3] != eack[d][(base + k) % 3])
                        s = (base + k) % 3;
                if (s >= 0) begin
                    g[d] = s;
                    gwe[d] = we_v[d][s];
                    gad[d] = addr_v[d][s];
                    gwd[d] = wd_v[d][s];
                    gbe[d] = be_v[d][s];
                    glog[d].push_back(s);
                    st[d] = 1;
                    dly[d] = $urandom_range(acc_hi, acc_lo);
                end
            end else if (st[d] == 1) begin
                if (dly[d] == 0) begin
                    if (gwe[d]) we_rdy[d] = 1'b0;
                    else rd_rdy[d] = 1'b0;
                    st[d] = 2;
                    dly[d] = $urandom_range(dn_hi, dn_lo);
                end else
                    dly[d]--;
            end else begin
                if (dly[d] == 0) begin
                    if (gwe[d])
                        we_rdy[d] = 1'b1;
                    else begin
                        dout[d] = force_v ? force_dout : $urandom;
                        rd_rdy[d] = 1'b1;
                        erd[d][g[d]] = dout[d];
                    end
                    eack[d][g[d]] = req[d][g[d]];
                    ptr[d] = (g[d] + 1) % 3;
                    st[d] = 0;
                end else
                    dly[d]--;
            end
        end
    endtask

    task automatic drain();
        bit quiet;
        p_tog = '{0, 0, 0};
        quiet = 1'b0;
        for (int n = 0; n < 400 && !quiet; n++) begin
            cycle();
            quiet = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (st[d] != 0) quiet = 1'b0;
                for (int c = 0; c < 3; c++)
                    if (req[d][c] != eack[d][c] || want[d][c]) quiet = 1'b0;
            end
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL drain: accesses still outstanding after 400 cycles");
        end
        cycle();
    endtask

    task automatic set_want(int c, logic w, logic [24:0] a, logic [31:0] wd, logic [3:0] b);
        want_we[c] = w;
        want_ad[c] = a;
        want_wd[c] = wd;
        want_be[c] = b;
        want[0][c] = 1'b1;
        want[1][c] = 1'b1;
    endtask

    function automatic logic [15:0] order(int d);
        logic [15:0] v = '0;
        for (int i = 0; i < 4 && i < glog[d].size(); i++)
            v[15 - 4 * i -: 4] = 4'(glog[d][i]);
        return v;
    endfunction

    initial begin
        int n, c2n, c1n;
        reset = 1'b1;
        model_reset();
        p_tog = '{0, 0, 0};
        acc_lo = 0; acc_hi = 3; dn_lo = 0; dn_hi = 3; wmode = -1;
        force_v = 1'b0; force_dout = '0;
        for (int d = 0; d < 2; d++) begin
            dout[d] = '0;
            for (int c = 0; c < 3; c++) begin
                we_v[d][c] = 1'b0; addr_v[d][c] = '0; wd_v[d][c] = '0; be_v[d][c] = '0;
            end
        end
        repeat (3) @(negedge clk);
        chk("rst_ack0", 0, ack_o[0][0], 0);
        chk("rst_rdata1", 0, rd_o[0][1], 0);
        chk("rst_sd_raddr", 0, raddr[0], 0);
        chk("rst_sd_waddr", 1, waddr[1], 0);
        chk("rst_sd_din", 0, din[0], 0);
        chk("rst_sd_be", 0, sbe[0], 0);

        // single read from c1 returning DEADBEEF
        force_v = 1'b1; force_dout = 32'hDEADBEEF;
        set_want(1, 1'b0, 25'h0000100, 32'h0, 4'h0);
        drain();
        force_v = 1'b0;
        chk("t1_rdata", 0, rd_o[0][1], 32'hDEADBEEF);
        chk("t1_ack", 0, ack_o[0][1], 1);
        chk("t1_other_rdata", 0, rd_o[0][0] | rd_o[0][2], 0);
        chk("t1_grant", 0, glog[0][glog[0].size() - 1], 1);

        // c2 partial write
        acc_lo = 2; acc_hi = 2;
        set_want(2, 1'b1, 25'h0400010, 32'h11223344, 4'b0011);
        drain();
        chk("t3_ack", 0, ack_o[0][2], 1);
        chk("t3_rdata", 0, rd_o[0][2], 0);

        // write held off by a long loader pre-emption
        acc_lo = 20; acc_hi = 20;
        set_want(0, 1'b1, 25'h1ABCDEF, 32'hCAFEF00D, 4'b0000);
        drain();
        chk("t4_ack", 0, ack_o[0][0], 1);

        // reset while a c0 read sits waiting for completion
        acc_lo = 0; acc_hi = 0; dn_lo = 5; dn_hi = 5;
        set_want(0, 1'b0, 25'h0000040, 32'h0, 4'h0);
        n = 0;
        do begin cycle(); n++; end while (st[0] != 2 && n < 50);
        chk("t5_reached_done", 0, st[0], 2);
        do_reset = 1'b1;
        cycle();
        cycle();
        chk("t5_ack0", 0, ack_o[0][0], 0);
        chk("t5_rdata0", 0, rd_o[0][0], 0);
        chk("t5_sd_rd", 0, sd_rd[0], 0);
        repeat (10) cycle();
        chk("t5_no_stale_ack", 0, ack_o[0][0], 0);

        // simultaneous requests, then c0 returns during c1's access
        acc_lo = 1; acc_hi = 1; dn_lo = 1; dn_hi = 1;
        glog[0].delete(); glog[1].delete();
        for (int c = 0; c < 3; c++) set_want(c, 1'b0, 25'(c * 16), 32'h0, 4'h0);
        n = 0;
        do begin cycle(); n++; end while (!(st[0] != 0 && g[0] == 1) && n < 100);
        chk("t2_c1_granted", 0, g[0], 1);
        set_want(0, 1'b0, 25'h0000080, 32'h0, 4'h0);
        drain();
        chk("t2_rr_order", 0, order(0), 16'h0120);
        chk("t2_fixed_order", 1, order(1), 16'h0102);
        chk("t2_count", 0, glog[0].size(), 4);

        // c1 and c2 requesting back to back
        acc_lo = 0; acc_hi = 2; dn_lo = 0; dn_hi = 2;
        glog[0].delete(); glog[1].delete();
        p_tog = '{0, 100, 100};
        repeat (300) cycle();
        c2n = 0; c1n = 0;
        foreach (glog[1][i]) begin
            if (glog[1][i] == 2) c2n++;
            if (glog[1][i] == 1) c1n++;
        end
        chk("t6_fixed_c2_starved", 1, c2n, 0);
        chk("t6_fixed_c1_served", 1, c1n > 10, 1);
        c2n = 0;
        foreach (glog[0][i]) if (glog[0][i] == 2) c2n++;
        chk("t6_rr_c2_served", 0, c2n > 5, 1);
        drain();

        // mixed random traffic
        acc_lo = 0; acc_hi = 4; dn_lo = 0; dn_hi = 4;
        p_tog = '{25, 25, 25};
        repeat (3000) cycle();
        acc_hi = 25;
        p_tog = '{60, 10, 40};
        repeat (2000) cycle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
